// File: rtl/dm_arbiter_if.sv
// Requester and RAM-side signal bundle for the data-memory arbiter.
// slave = arbiter view, master = requesters + RAM view.
interface dm_arbiter_if #(parameter int ADDR_W = 13);
  logic              req0, req1, we0, we1;
  logic [31:0]       addr0, addr1, wd0, wd1;
  logic [3:0]        be0, be1;
  logic              gnt0, gnt1, ack0, ack1;
  logic [31:0]       rd0, rd1;
  logic [ADDR_W-1:0] mem_addr;
  logic [3:0]        mem_we;
  logic [31:0]       mem_wd, mem_rd;
  logic              busy;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wd0, wd1, be0, be1, mem_rd,
    output gnt0, gnt1, ack0, ack1, rd0, rd1, mem_addr, mem_we, mem_wd, busy
  );
  modport master (
    output req0, req1, we0, we1, addr0, addr1, wd0, wd1, be0, be1, mem_rd,
    input  gnt0, gnt1, ack0, ack1, rd0, rd1, mem_addr, mem_we, mem_wd, busy
  );
endinterface

// File: rtl/dm_arbiter.sv
// Two-port arbiter/sequencer for a byte-enabled, 1-cycle synchronous-read
// data RAM. One transaction in flight; round-robin or fixed priority.
module dm_arbiter #(
  parameter int ADDR_W       = 13,
  parameter int PRIO_MODE    = 0,
  parameter int STARVE_LIMIT = 4
) (
  input  logic         clk,
  input  logic         reset,
  dm_arbiter_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

  state_e            state_q, state_d;
  logic              owner_q, we_q;
  logic              rr_last_q, rr_last_d;
  logic [3:0]        starve_q, starve_d;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wd_q, rd0_q, rd1_q;
  logic [3:0]        be_q;
  logic              grant, win;

  // win = 1 selects port 1
  always_comb begin : arb
    win = 1'b0;
    if (PRIO_MODE == 0) win = bus.req1 & (~bus.req0 | ~rr_last_q);
    else                win = bus.req1 & (~bus.req0 | (starve_q >= 4'(STARVE_LIMIT)));
  end

  always_comb begin : fsm
    state_d     = state_q;
    grant       = 1'b0;
    rr_last_d   = rr_last_q;
    starve_d    = starve_q;
    bus.gnt0    = 1'b0;
    bus.gnt1    = 1'b0;
    bus.ack0    = 1'b0;
    bus.ack1    = 1'b0;
    bus.mem_we  = 4'b0000;
    case (state_q)
      IDLE: if (bus.req0 | bus.req1) begin
        grant     = 1'b1;
        bus.gnt0  = ~win;
        bus.gnt1  = win;
        rr_last_d = win;
        state_d   = ISSUE;
      end
      ISSUE: begin
        bus.mem_we = we_q ? be_q : 4'b0000;
        if (we_q) begin
          bus.ack0 = ~owner_q;
          bus.ack1 = owner_q;
          state_d  = IDLE;
        end else begin
          state_d  = WAIT;
        end
      end
      WAIT: state_d = RESP;
      RESP: begin
        bus.ack0 = ~owner_q;
        bus.ack1 = owner_q;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (!bus.req1)
      starve_d = 4'd0;
    else if (grant && !win)
      starve_d = (starve_q < 4'(STARVE_LIMIT)) ? starve_q + 4'd1 : starve_q;
    else if (grant && win)
      starve_d = 4'd0;
    // the abort cycle must not leak a strobe onto the RAM or requesters
    if (reset) begin
      bus.gnt0   = 1'b0;
      bus.gnt1   = 1'b0;
      bus.ack0   = 1'b0;
      bus.ack1   = 1'b0;
      bus.mem_we = 4'b0000;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      owner_q   <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wd_q      <= '0;
      be_q      <= '0;
      rd0_q     <= '0;
      rd1_q     <= '0;
      rr_last_q <= 1'b1;
      starve_q  <= '0;
    end else begin
      state_q   <= state_d;
      rr_last_q <= rr_last_d;
      starve_q  <= starve_d;
      if (grant) begin
        owner_q <= win;
        we_q    <= win ? bus.we1 : bus.we0;
        addr_q  <= win ? bus.addr1[ADDR_W+1:2] : bus.addr0[ADDR_W+1:2];
        wd_q    <= win ? bus.wd1 : bus.wd0;
        be_q    <= win ? bus.be1 : bus.be0;
      end
      if (state_q == WAIT) begin
        if (owner_q) rd1_q <= bus.mem_rd;
        else         rd0_q <= bus.mem_rd;
      end
    end
  end

  assign bus.mem_addr = addr_q;
  assign bus.mem_wd   = wd_q;
  assign bus.rd0      = rd0_q;
  assign bus.rd1      = rd1_q;
  assign bus.busy     = (state_q != IDLE);

  logic unused_ok;
  assign unused_ok = ^{bus.addr0[1:0], bus.addr1[1:0],
                       bus.addr0[31:ADDR_W+2], bus.addr1[31:ADDR_W+2]};
endmodule
